temp_monitor_sequencer: RTL and testbench
=========================================

Name: temp_monitor_sequencer

Overview:
Controls the temperature-measurement side of the monitor path. It raises ENMONTSENSE, waits for the sensor to settle and then fires a one-cycle ADC_START. It waits for the ADC's DONE, then drops ENMONTSENSE, so the downstream temperature buffer captures exactly one RESULT per measurement. Measurements run periodically or on a single-shot trigger, all in the SAMPLE_CLK domain.

Parameters:
SETTLE_CYCLES, 16, cycles from ENMONTSENSE rising to ADC_START; values below 2 are treated as 2
PERIOD_W, 16, width of PERIOD and the interval counter
TIMEOUT_CYCLES, 1023, max cycles in WAIT_DONE before abort (only with TEMPMON_TIMEOUT_EN)

Ports:
SAMPLE_CLK  input  1  clock; all logic on rising edge
NRST_sync  input  1  asynchronous active-low reset
TEMPMON_EN  input  1  master enable, synchronous level
PERIOD  input  PERIOD_W  start-to-start interval in cycles; 0 = periodic mode off
TRIG  input  1  single-shot request, sampled per cycle
DONE  input  1  ADC conversion complete, one-cycle pulse
ENMONTSENSE  output  1  sensor/channel enable, registered
ADC_START  output  1  conversion request, one-cycle pulse, registered
BUSY  output  1  high in any state except IDLE
MEAS_DONE  output  1  one-cycle pulse: measurement completed and RESULT valid downstream
TIMEOUT_ERR  output  1  sticky abort flag

Behaviour:
- Reset: state=IDLE; all counters 0; pending=0; ENMONTSENSE=0, ADC_START=0, BUSY=0, MEAS_DONE=0, TIMEOUT_ERR=0. Reset mid-measurement drops ENMONTSENSE immediately.
- States: IDLE, SETTLE, CONVERT, WAIT_DONE, GAP.
- Start condition in IDLE: TEMPMON_EN=1 and any of the following: TRIG=1; pending=1; interval counter expiring this cycle.
- IDLE -> SETTLE on start. ENMONTSENSE=1 from the next cycle, call it N.
- SETTLE counts SETTLE_CYCLES-1 cycles, then -> CONVERT. ADC_START=1 exactly on cycle N+SETTLE_CYCLES-1+1, i.e. N+SETTLE_CYCLES, for one cycle only. CONVERT -> WAIT_DONE.
- WAIT_DONE, DONE=1 on cycle M:
  - ENMONTSENSE stays 1 through cycle M.
  - -> GAP; ENMONTSENSE=0 and MEAS_DONE=1 on cycle M+1.
  - GAP lasts exactly one cycle, guaranteeing at least 1 low cycle between measurements so the buffer re-arms. -> IDLE; BUSY=0 from M+2.
- DONE outside WAIT_DONE is ignored, with no MEAS_DONE. DONE in the same cycle as ADC_START (CONVERT) is ignored.
- Interval counter:
  - Active when TEMPMON_EN=1 and PERIOD!=0. Reloads to PERIOD-1 on every start and on TEMPMON_EN rising edge, then decrements. Expiry means the counter is 0.
  - Expiry while not IDLE sets pending. pending clears on the next start. PERIOD=1 therefore yields back-to-back measurements separated only by GAP.
  - PERIOD changes take effect at the next reload.
- TRIG while BUSY: ignored, not queued. TRIG and expiry in the same IDLE cycle: a single start.
- TEMPMON_EN=0 in any non-IDLE state:
  - Next state is GAP; ENMONTSENSE=0 the next cycle; no MEAS_DONE.
  - An ADC_START not yet issued is suppressed.
  - A late DONE is ignored.
  - pending clears and the counter holds at 0.
- TIMEOUT_ERR: cleared only by reset or by a start; held otherwise.

Optional Feature:
TEMPMON_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles in WAIT_DONE.
  - If TIMEOUT_CYCLES elapse without DONE: -> GAP, ENMONTSENSE=0 next cycle, TIMEOUT_ERR=1, no MEAS_DONE.
  - DONE on the final timeout cycle counts as success.
- Undefined: WAIT_DONE waits indefinitely and TIMEOUT_ERR is tied to 0.

Test Plan:
- Single shot, SETTLE_CYCLES=16, PERIOD=0, TRIG at cycle 10 -> ENMONTSENSE high from 11; ADC_START only at 27. DONE at 40 -> ENMONTSENSE low at 41, MEAS_DONE pulse at 41, BUSY low at 42.
- Periodic, PERIOD=100, DONE returned 5 cycles after ADC_START -> ADC_START every 100 cycles exactly, 10 consecutive; ENMONTSENSE has a low gap of at least 1 cycle before each rise.
- Periodic, PERIOD=10 shorter than the measurement -> pending set; each new start occurs exactly 1 cycle after GAP; no overlapping ENMONTSENSE high periods.
- TEMPMON_EN dropped 3 cycles after ADC_START, then DONE pulsed -> ENMONTSENSE low the next cycle, no MEAS_DONE, state IDLE; a later TRIG measures normally.
- Stray DONE in IDLE and SETTLE, plus TRIG while BUSY -> no output change, no extra ADC_START.
- With TEMPMON_TIMEOUT_EN, TIMEOUT_CYCLES=1023, DONE never returned -> abort after 1023 WAIT_DONE cycles, TIMEOUT_ERR=1; it clears on the next TRIG start. Asserting NRST_sync mid-SETTLE clears all outputs asynchronously.

Source files
------------

// File: rtl/temp_monitor_sequencer_if.sv
// Handshake bundle between the temperature-monitor sequencer and its controller/ADC side.
interface temp_monitor_sequencer_if #(
  parameter int PERIOD_W = 16
);
  logic                TEMPMON_EN;
  logic [PERIOD_W-1:0] PERIOD;
  logic                TRIG;
  logic                DONE;
  logic                ENMONTSENSE;
  logic                ADC_START;
  logic                BUSY;
  logic                MEAS_DONE;
  logic                TIMEOUT_ERR;

  modport master (
    output TEMPMON_EN, PERIOD, TRIG, DONE,
    input  ENMONTSENSE, ADC_START, BUSY, MEAS_DONE, TIMEOUT_ERR
  );

  modport slave (
    input  TEMPMON_EN, PERIOD, TRIG, DONE,
    output ENMONTSENSE, ADC_START, BUSY, MEAS_DONE, TIMEOUT_ERR
  );
endinterface

// File: rtl/temp_monitor_sequencer.sv
// Sequences sensor enable, settle delay, ADC start and DONE capture for one temperature sample.
// Optional WAIT_DONE watchdog enabled by defining TEMPMON_TIMEOUT_EN.
module temp_monitor_sequencer #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int PERIOD_W       = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          SAMPLE_CLK,
  input  logic                          NRST_sync,
  temp_monitor_sequencer_if.slave       bus
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 2) ? 2 : SETTLE_CYCLES;
  localparam int SW         = $clog2(SETTLE_EFF + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    CONVERT   = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [PERIOD_W-1:0] ivl_q, ivl_d;
  logic                pend_q, pend_d;
  logic                en_q;
  logic                enmon_q, enmon_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                mdone_q, mdone_d;

  logic ivl_active;
  logic en_rise;
  logic expiry;
  logic start;

`ifdef TEMPMON_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          tmo_err_q, tmo_err_d;
`endif

  // Expiry is masked on the enable rising edge, where the counter is being reloaded.
  assign ivl_active = bus.TEMPMON_EN && (bus.PERIOD != '0);
  assign en_rise    = bus.TEMPMON_EN && !en_q;
  assign expiry     = ivl_active && !en_rise && (ivl_q == '0);
  assign start      = (state_q == IDLE) && bus.TEMPMON_EN &&
                      (bus.TRIG || pend_q || expiry);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    mdone_d  = 1'b0;
`ifdef TEMPMON_TIMEOUT_EN
    wd_d      = wd_q;
    tmo_err_d = tmo_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          settle_d = '0;
`ifdef TEMPMON_TIMEOUT_EN
          tmo_err_d = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (!bus.TEMPMON_EN) begin
          state_d = GAP;
        end else if (settle_q == SW'(SETTLE_EFF - 1)) begin
          state_d = CONVERT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      CONVERT: begin
        // DONE coincident with ADC_START cannot belong to this conversion.
        state_d = bus.TEMPMON_EN ? WAIT_DONE : GAP;
`ifdef TEMPMON_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      WAIT_DONE: begin
        if (!bus.TEMPMON_EN) begin
          state_d = GAP;
        end else if (bus.DONE) begin
          state_d = GAP;
          mdone_d = 1'b1;
        end
`ifdef TEMPMON_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = GAP;
          tmo_err_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    enmon_d = (state_d == SETTLE) || (state_d == CONVERT) || (state_d == WAIT_DONE);
    start_d = (state_d == CONVERT);
    busy_d  = (state_d != IDLE);
  end

  always_comb begin
    ivl_d  = ivl_q;
    pend_d = pend_q;
    if (!ivl_active) begin
      ivl_d = '0;
    end else if (start || en_rise) begin
      ivl_d = bus.PERIOD - PERIOD_W'(1);
    end else if (ivl_q != '0) begin
      ivl_d = ivl_q - PERIOD_W'(1);
    end

    // An interval that expires mid-measurement is remembered and serviced from IDLE.
    if (!bus.TEMPMON_EN || start) begin
      pend_d = 1'b0;
    end else if (expiry && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ivl_q    <= '0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      enmon_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      mdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ivl_q    <= ivl_d;
      pend_q   <= pend_d;
      en_q     <= bus.TEMPMON_EN;
      enmon_q  <= enmon_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      mdone_q  <= mdone_d;
    end
  end

`ifdef TEMPMON_TIMEOUT_EN
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      wd_q      <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.TIMEOUT_ERR = tmo_err_q;
`else
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

  assign bus.ENMONTSENSE = enmon_q;
  assign bus.ADC_START   = start_q;
  assign bus.BUSY        = busy_q;
  assign bus.MEAS_DONE   = mdone_q;

endmodule

// File: tb/tb_temp_monitor_sequencer.sv
// Directed bench for temp_monitor_sequencer: single shot, periodic, pending, abort, stray inputs, reset.
module tb_temp_monitor_sequencer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   adc_cnt;
  int   meas_cnt;

  temp_monitor_sequencer_if #(.PERIOD_W(16)) bus ();

  temp_monitor_sequencer #(
    .SETTLE_CYCLES (16),
    .PERIOD_W      (16),
    .TIMEOUT_CYCLES(1023)
  ) dut (
    .SAMPLE_CLK(clk),
    .NRST_sync (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ADC_START === 1'b1) adc_cnt++;
    if (bus.MEAS_DONE === 1'b1) meas_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int last, nst, g, base_adc, base_meas;
    logic prev_en;
    errors = 0; checks = 0; adc_cnt = 0; meas_cnt = 0;
    rst_n = 1'b0;
    bus.TEMPMON_EN = 1'b0; bus.PERIOD = '0; bus.TRIG = 1'b0; bus.DONE = 1'b0;
    repeat (3) tick();
    chk("rst_enmon", bus.ENMONTSENSE, 0);
    chk("rst_adc",   bus.ADC_START, 0);
    chk("rst_busy",  bus.BUSY, 0);
    chk("rst_meas",  bus.MEAS_DONE, 0);
    chk("rst_tmo",   bus.TIMEOUT_ERR, 0);
    rst_n = 1'b1;
    tick();
    bus.TEMPMON_EN = 1'b1;
    repeat (2) tick();

    // Single shot: TRIG in cycle 10
    bus.TRIG = 1'b1;
    tick();                                   // 11
    bus.TRIG = 1'b0;
    chk("ss_enmon_11", bus.ENMONTSENSE, 1);
    chk("ss_busy_11",  bus.BUSY, 1);
    chk("ss_adc_11",   bus.ADC_START, 0);
    repeat (15) tick();                       // 26
    chk("ss_adc_26", bus.ADC_START, 0);
    tick();                                   // 27
    chk("ss_adc_27", bus.ADC_START, 1);
    tick();                                   // 28
    chk("ss_adc_28",   bus.ADC_START, 0);
    chk("ss_enmon_28", bus.ENMONTSENSE, 1);
    repeat (12) tick();                       // 40
    bus.DONE = 1'b1;
    chk("ss_enmon_40", bus.ENMONTSENSE, 1);
    tick();                                   // 41
    bus.DONE = 1'b0;
    chk("ss_enmon_41", bus.ENMONTSENSE, 0);
    chk("ss_meas_41",  bus.MEAS_DONE, 1);
    chk("ss_busy_41",  bus.BUSY, 1);
    tick();                                   // 42
    chk("ss_busy_42", bus.BUSY, 0);
    chk("ss_meas_42", bus.MEAS_DONE, 0);

    // Periodic, PERIOD=100, DONE 5 cycles after ADC_START
    base_meas = meas_cnt;
    last = 0; nst = 0;
    bus.PERIOD = 16'd100;
    for (int k = 1; k <= 960; k++) begin
      tick();
      bus.DONE = (nst > 0) && (k == last + 5);
      if (bus.MEAS_DONE === 1'b1) chk("per_enmon_gap", bus.ENMONTSENSE, 0);
      if (bus.ADC_START === 1'b1) begin
        if (nst > 0) chk("per_interval", k - last, 100);
        last = k;
        nst++;
      end
    end
    bus.DONE = 1'b0;
    bus.PERIOD = '0;
    repeat (5) tick();
    chk("per_nstart", nst, 10);
    chk("per_nmeas",  meas_cnt - base_meas, 10);
    chk("per_idle",   bus.BUSY, 0);

    // Periodic, PERIOD=10: pending drives back-to-back measurements
    last = 0; nst = 0; g = 0; prev_en = 1'b0;
    bus.PERIOD = 16'd10;
    for (int k = 1; k <= 100; k++) begin
      tick();
      bus.DONE = (nst > 0) && (k == last + 5);
      if (bus.MEAS_DONE === 1'b1) begin
        chk("pend_enmon_gap", bus.ENMONTSENSE, 0);
        g = k;
      end
      if (bus.ENMONTSENSE === 1'b1 && !prev_en && g > 0) chk("pend_restart", k - g, 2);
      prev_en = bus.ENMONTSENSE;
      if (bus.ADC_START === 1'b1) begin
        if (nst > 0) chk("pend_interval", k - last, 24);
        last = k;
        nst++;
      end
    end
    bus.DONE = 1'b0;
    bus.PERIOD = '0;
    bus.TEMPMON_EN = 1'b0;
    repeat (3) tick();
    chk("pend_nstart", nst, 4);
    chk("pend_off_busy",  bus.BUSY, 0);
    chk("pend_off_enmon", bus.ENMONTSENSE, 0);
    bus.TEMPMON_EN = 1'b1;
    repeat (2) tick();

    // Enable dropped 3 cycles after ADC_START, then late DONE
    base_meas = meas_cnt;
    bus.TRIG = 1'b1;
    tick();
    bus.TRIG = 1'b0;
    repeat (16) tick();
    chk("ab_adc", bus.ADC_START, 1);
    repeat (3) tick();
    bus.TEMPMON_EN = 1'b0;
    tick();
    chk("ab_enmon", bus.ENMONTSENSE, 0);
    chk("ab_meas",  bus.MEAS_DONE, 0);
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("ab_busy",  bus.BUSY, 0);
    chk("ab_meas2", bus.MEAS_DONE, 0);
    chk("ab_nmeas", meas_cnt - base_meas, 0);
    bus.TEMPMON_EN = 1'b1;
    tick();
    bus.TRIG = 1'b1;
    tick();
    bus.TRIG = 1'b0;
    repeat (16) tick();
    chk("ab_re_adc", bus.ADC_START, 1);
    repeat (5) tick();
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("ab_re_meas", bus.MEAS_DONE, 1);
    tick();
    chk("ab_re_busy", bus.BUSY, 0);

    // Stray DONE in IDLE/SETTLE, TRIG while busy, DONE with ADC_START
    base_adc = adc_cnt; base_meas = meas_cnt;
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("st_idle_meas", bus.MEAS_DONE, 0);
    chk("st_idle_busy", bus.BUSY, 0);
    bus.TRIG = 1'b1;
    tick();                                   // 1
    bus.TRIG = 1'b0;
    repeat (4) tick();                        // 5
    bus.DONE = 1'b1; bus.TRIG = 1'b1;
    tick();                                   // 6
    bus.DONE = 1'b0; bus.TRIG = 1'b0;
    chk("st_settle_enmon", bus.ENMONTSENSE, 1);
    chk("st_settle_meas",  bus.MEAS_DONE, 0);
    repeat (11) tick();                       // 17
    chk("st_adc", bus.ADC_START, 1);
    bus.DONE = 1'b1;
    tick();                                   // 18
    bus.DONE = 1'b0;
    chk("st_conv_done_meas",  bus.MEAS_DONE, 0);
    chk("st_conv_done_enmon", bus.ENMONTSENSE, 1);
    repeat (3) tick();                        // 21
    bus.DONE = 1'b1;
    tick();                                   // 22
    bus.DONE = 1'b0;
    chk("st_meas", bus.MEAS_DONE, 1);
    repeat (20) tick();
    chk("st_busy",  bus.BUSY, 0);
    chk("st_nadc",  adc_cnt - base_adc, 1);
    chk("st_nmeas", meas_cnt - base_meas, 1);

`ifdef TEMPMON_TIMEOUT_EN
    // Watchdog abort after 1023 WAIT_DONE cycles
    bus.TRIG = 1'b1;
    tick();
    bus.TRIG = 1'b0;
    repeat (16) tick();                       // 17
    chk("to_adc", bus.ADC_START, 1);
    repeat (1023) tick();                     // 1040
    chk("to_enmon_last", bus.ENMONTSENSE, 1);
    chk("to_err_last",   bus.TIMEOUT_ERR, 0);
    tick();                                   // 1041
    chk("to_enmon", bus.ENMONTSENSE, 0);
    chk("to_err",   bus.TIMEOUT_ERR, 1);
    chk("to_meas",  bus.MEAS_DONE, 0);
    repeat (5) tick();
    chk("to_busy",   bus.BUSY, 0);
    chk("to_sticky", bus.TIMEOUT_ERR, 1);
    bus.TRIG = 1'b1;
    tick();
    bus.TRIG = 1'b0;
    chk("to_clear", bus.TIMEOUT_ERR, 0);
    repeat (16) tick();
    repeat (3) tick();
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    chk("to_meas_ok", bus.MEAS_DONE, 1);
    repeat (2) tick();
`else
    chk("tmo_tied", bus.TIMEOUT_ERR, 0);
`endif

    // Asynchronous reset in the middle of SETTLE
    bus.TRIG = 1'b1;
    tick();
    bus.TRIG = 1'b0;
    repeat (3) tick();
    chk("ar_enmon_pre", bus.ENMONTSENSE, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_enmon", bus.ENMONTSENSE, 0);
    chk("ar_busy",  bus.BUSY, 0);
    chk("ar_adc",   bus.ADC_START, 0);
    chk("ar_meas",  bus.MEAS_DONE, 0);
    chk("ar_tmo",   bus.TIMEOUT_ERR, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("ar_after_busy", bus.BUSY, 0);
    chk("ar_after_adc",  bus.ADC_START, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
